// File: rtl/alu_pkg.sv
// Shared definitions for the ALU consumer stage and later compare units:
// flag bit positions, RISC-V branch funct3 codes and the stored entry format.
package alu_pkg;

    localparam int ALU_XLEN = 32;
    localparam int ALU_RA_W = 5;

    // Bit positions inside the 4-bit flag vector {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Branch condition codes (RISC-V funct3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // One pipeline entry as held in the main and skid slots
    typedef struct packed {
        logic [ALU_XLEN-1:0] result;
        logic [ALU_RA_W-1:0] rd;
        logic                regwrite;
        logic                taken;
        logic [ALU_XLEN-1:0] target;
        logic                illegal;
    } stage_entry_t;

endpackage

// File: rtl/alu_branch_stage_if.sv
// Bundle of all handshake and payload signals around alu_branch_stage.
// slave = the stage itself, master = whoever drives it (upstream/downstream).
interface alu_branch_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_result;
    logic [3:0]      in_flags;
    logic            in_branch;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [RA_W-1:0] in_rd;
    logic            in_regwrite;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [RA_W-1:0] out_rd;
    logic            out_regwrite;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;
    logic [3:0]      last_flags;

    modport slave (
        input  flush, in_valid, in_result, in_flags, in_branch, in_funct3,
               in_pc, in_imm, in_rd, in_regwrite, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_regwrite,
               out_taken, out_target, out_illegal, last_flags
    );

    modport master (
        output flush, in_valid, in_result, in_flags, in_branch, in_funct3,
               in_pc, in_imm, in_rd, in_regwrite, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_regwrite,
               out_taken, out_target, out_illegal, last_flags
    );
endinterface

// File: rtl/alu_branch_stage_branch_cond.sv
// Combinational RISC-V branch decision from the flags of A-B.
module branch_cond
    import alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] funct3,
    input  logic       branch,
    output logic       taken,
    output logic       illegal
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition; non-branch entries are never taken nor illegal
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (branch) begin
            case (funct3)
                F3_BEQ:  taken = z;
                F3_BNE:  taken = ~z;
                F3_BLT:  taken = n ^ v;
                F3_BGE:  taken = ~(n ^ v);
                F3_BLTU: taken = ~c;
                F3_BGEU: taken = c;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_branch_stage.sv
// ALU result register stage with a 2-entry skid buffer, branch evaluation
// on the input side and a sticky copy of the last accepted flags.
module alu_branch_stage
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int RA_W = ALU_RA_W
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_branch_stage_if.slave  bus
);

    logic            br_taken;
    logic            br_illegal;
    logic [XLEN-1:0] target_w;
    logic [RA_W-1:0] rd_w;
    stage_entry_t    in_entry;

    logic            in_xfer;
    logic            m_leave;

    stage_entry_t    m_q, m_d, s_q, s_d;
    logic            m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic [3:0]      last_flags_q, last_flags_d;

    branch_cond u_branch_cond (
        .flags   (bus.in_flags),
        .funct3  (bus.in_funct3),
        .branch  (bus.in_branch),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    assign target_w = bus.in_pc + bus.in_imm;
    assign rd_w     = bus.in_rd;

    // Assemble the incoming entry; branches never write a register
    always_comb begin
        in_entry          = '0;
        in_entry.result   = bus.in_result;
        in_entry.rd       = rd_w;
        in_entry.regwrite = bus.in_regwrite & ~bus.in_branch;
        in_entry.taken    = br_taken;
        in_entry.target   = target_w;
        in_entry.illegal  = br_illegal;
    end

    // in_ready comes straight from the skid valid flop, so out_ready never
    // reaches it combinationally
    assign in_xfer = bus.in_valid & ~s_vld_q;
    assign m_leave = m_vld_q & bus.out_ready;

    // Next-state for the main/skid slots and the sticky flags
    always_comb begin
        m_d          = m_q;
        s_d          = s_q;
        m_vld_d      = m_vld_q;
        s_vld_d      = s_vld_q;
        last_flags_d = in_xfer ? bus.in_flags : last_flags_q;

        if (bus.flush) begin
            // Squash everything, including an entry arriving this cycle
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (!m_vld_q || m_leave) begin
            if (s_vld_q) begin
                m_d     = s_q;
                m_vld_d = 1'b1;
                if (in_xfer) begin
                    s_d     = in_entry;
                    s_vld_d = 1'b1;
                end else begin
                    s_vld_d = 1'b0;
                end
            end else if (in_xfer) begin
                m_d     = in_entry;
                m_vld_d = 1'b1;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            // Main is stalled: park the new entry in the skid slot
            s_d     = in_entry;
            s_vld_d = 1'b1;
        end
    end

    // State registers; all storage cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q          <= '0;
            s_q          <= '0;
            m_vld_q      <= 1'b0;
            s_vld_q      <= 1'b0;
            last_flags_q <= '0;
        end else begin
            m_q          <= m_d;
            s_q          <= s_d;
            m_vld_q      <= m_vld_d;
            s_vld_q      <= s_vld_d;
            last_flags_q <= last_flags_d;
        end
    end

    assign bus.in_ready     = ~s_vld_q;
    assign bus.out_valid    = m_vld_q;
    assign bus.out_result   = m_q.result;
    assign bus.out_rd       = m_q.rd;
    assign bus.out_regwrite = m_q.regwrite;
    assign bus.out_taken    = m_q.taken;
    assign bus.out_target   = m_q.target;
    assign bus.out_illegal  = m_q.illegal;
    assign bus.last_flags   = last_flags_q;

endmodule

// File: tb/tb_alu_branch_stage.sv
// Directed bench for alu_branch_stage with hand-computed expectations.
module tb_alu_branch_stage;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    alu_branch_stage_if #(.XLEN(32), .RA_W(5)) bus ();

    alu_branch_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] fl,
                         input logic br, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [4:0] rd, input logic rw);
        bus.in_valid    = v;
        bus.in_result   = res;
        bus.in_flags    = fl;
        bus.in_branch   = br;
        bus.in_funct3   = f3;
        bus.in_pc       = pc;
        bus.in_imm      = imm;
        bus.in_rd       = rd;
        bus.in_regwrite = rw;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n       = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        // Reset state
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_last_flags", {28'b0, bus.last_flags}, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_target", bus.out_target, 32'd0);
        #12;
        reset_n = 1'b1;
        tick();

        // BEQ taken with Z=1,C=1
        drive(1'b1, 32'h5, 4'b0110, 1'b1, 3'b000, 32'h100, 32'h20, 5'd3, 1'b1);
        tick();
        chk("beq_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("beq_taken", {31'b0, bus.out_taken}, 32'd1);
        chk("beq_target", bus.out_target, 32'h120);
        chk("beq_regwrite", {31'b0, bus.out_regwrite}, 32'd0);
        chk("beq_last_flags", {28'b0, bus.last_flags}, 32'h6);
        // BNE same flags, not taken
        drive(1'b1, 32'h5, 4'b0110, 1'b1, 3'b001, 32'h100, 32'h20, 5'd3, 1'b1);
        tick();
        chk("bne_taken", {31'b0, bus.out_taken}, 32'd0);
        chk("bne_illegal", {31'b0, bus.out_illegal}, 32'd0);

        // 0xFFFFFFFF - 1: N=1,Z=0,C=1,V=0
        drive(1'b1, 32'hFFFFFFFE, 4'b1010, 1'b1, 3'b100, 32'h200, 32'h8, 5'd1, 1'b0);
        tick();
        chk("blt_taken", {31'b0, bus.out_taken}, 32'd1);
        drive(1'b1, 32'hFFFFFFFE, 4'b1010, 1'b1, 3'b110, 32'h200, 32'h8, 5'd1, 1'b0);
        tick();
        chk("bltu_taken", {31'b0, bus.out_taken}, 32'd0);
        drive(1'b1, 32'hFFFFFFFE, 4'b1010, 1'b1, 3'b111, 32'hFFFFFFF0, 32'h20, 5'd1, 1'b0);
        tick();
        chk("bgeu_taken", {31'b0, bus.out_taken}, 32'd1);
        chk("target_wrap", bus.out_target, 32'h10);
        drive(1'b1, 32'hFFFFFFFE, 4'b1010, 1'b1, 3'b101, 32'h200, 32'h8, 5'd1, 1'b0);
        tick();
        chk("bge_taken", {31'b0, bus.out_taken}, 32'd0);
        // Non-branch keeps regwrite and is never taken
        drive(1'b1, 32'h1234, 4'b0100, 1'b0, 3'b000, 32'h300, 32'h4, 5'd7, 1'b1);
        tick();
        chk("alu_taken", {31'b0, bus.out_taken}, 32'd0);
        chk("alu_regwrite", {31'b0, bus.out_regwrite}, 32'd1);
        chk("alu_rd", {27'b0, bus.out_rd}, 32'd7);
        chk("alu_result", bus.out_result, 32'h1234);
        bus.in_valid = 1'b0;
        tick();
        chk("idle_valid", {31'b0, bus.out_valid}, 32'd0);

        // Backpressure with three queued entries
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA, 4'h0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd2, 1'b1);
        chk("bp_ready0", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("bp_ready1", {31'b0, bus.in_ready}, 32'd1);
        chk("bp_res_a0", bus.out_result, 32'hA);
        drive(1'b1, 32'hB, 4'h0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd2, 1'b1);
        tick();
        chk("bp_ready2", {31'b0, bus.in_ready}, 32'd0);
        chk("bp_res_a1", bus.out_result, 32'hA);
        drive(1'b1, 32'hC, 4'h0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd2, 1'b1);
        tick();
        chk("bp_ready3", {31'b0, bus.in_ready}, 32'd0);
        chk("bp_res_a2", bus.out_result, 32'hA);
        chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        chk("bp_drain_a", bus.out_result, 32'hA);
        tick();
        chk("bp_drain_b", bus.out_result, 32'hB);
        chk("bp_ready4", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("bp_drain_c", bus.out_result, 32'hC);
        chk("bp_drain_c_v", {31'b0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_empty", {31'b0, bus.out_valid}, 32'd0);

        // Full throughput
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + i, 4'h0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd4, 1'b1);
            tick();
            chk("tp_result", bus.out_result, 32'h100 + i);
            chk("tp_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("tp_ready", {31'b0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();

        // Flush while both slots are full
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hD1, 4'h3, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        drive(1'b1, 32'hD2, 4'h3, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        chk("fl_full", {31'b0, bus.in_ready}, 32'd0);
        drive(1'b1, 32'hEE, 4'h9, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("fl_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("fl_flags_held", {28'b0, bus.last_flags}, 32'h3);
        bus.out_ready = 1'b1;
        tick();
        chk("fl_no_ghost", {31'b0, bus.out_valid}, 32'd0);
        // Flush with main only: the arriving entry is dropped but its flags stick
        drive(1'b1, 32'hD3, 4'h3, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        drive(1'b1, 32'hEF, 4'h9, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl2_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("fl2_flags", {28'b0, bus.last_flags}, 32'h9);

        // Illegal funct3 codes
        drive(1'b1, 32'h0, 4'b0100, 1'b1, 3'b010, 32'h40, 32'h4, 5'd0, 1'b0);
        tick();
        chk("ill010", {31'b0, bus.out_illegal}, 32'd1);
        chk("ill010_taken", {31'b0, bus.out_taken}, 32'd0);
        drive(1'b1, 32'h0, 4'b0100, 1'b1, 3'b011, 32'h40, 32'h4, 5'd0, 1'b0);
        tick();
        chk("ill011", {31'b0, bus.out_illegal}, 32'd1);

        // Asynchronous reset between edges
        drive(1'b1, 32'h77, 4'hF, 1'b0, 3'b000, 32'h0, 32'h0, 5'd6, 1'b1);
        tick();
        chk("ar_pre_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ar_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("ar_flags", {28'b0, bus.last_flags}, 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        chk("ar_idle", {31'b0, bus.out_valid}, 32'd0);
        drive(1'b1, 32'h88, 4'h1, 1'b0, 3'b000, 32'h0, 32'h0, 5'd6, 1'b1);
        tick();
        chk("ar_first_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("ar_first_result", bus.out_result, 32'h88);
        bus.in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_branch_stage.md
Name: alu_branch_stage

Overview:
Downstream consumer of the 32-bit ALU (Result, 4-bit Flags = {N,Z,C,V}).
- Registers the ALU result into the next pipeline stage through a valid/ready handshake with a 2-entry skid buffer.
- Evaluates RISC-V branch conditions from the ALU flags of a SUB (A-B) and computes the branch target PC+imm.
- Keeps a sticky copy of the last accepted flags for debug and CSR read.

Parameters:
XLEN, 32, datapath width of result, PC and immediate.
RA_W, 5, destination register index width.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous squash of all held entries.
in_valid  input  1  upstream entry valid.
in_ready  output  1  stage can accept an entry.
in_result  input  XLEN  ALU Result.
in_flags  input  4  ALU Flags {N,Z,C,V}; bit 3 = N.
in_branch  input  1  entry is a conditional branch.
in_funct3  input  3  branch condition code (RISC-V funct3).
in_pc  input  XLEN  instruction PC.
in_imm  input  XLEN  sign-extended branch offset.
in_rd  input  RA_W  destination register.
in_regwrite  input  1  entry writes rd.
out_valid  output  1  output entry valid.
out_ready  input  1  downstream accepts.
out_result  output  XLEN  registered result.
out_rd  output  RA_W  registered rd.
out_regwrite  output  1  registered regwrite; forced 0 for branches.
out_taken  output  1  branch taken; 0 for non-branch entries.
out_target  output  XLEN  in_pc+in_imm, mod 2^XLEN.
out_illegal  output  1  branch entry with funct3 010 or 011.
last_flags  output  4  flags of the most recent accepted entry.

Behaviour:
- Reset (async, reset_n=0): both entry valid bits = 0, out_valid=0, in_ready=1, last_flags=0. All other outputs are 0.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, all out_* stay stable.
- Storage: main entry M drives out_*. Skid entry S is filled only when an input transfer occurs while M is valid and not leaving.
- in_ready = ~S.valid, taken from a register with no combinational path from out_ready.
- Latency is 1 cycle from input transfer to out_valid. Throughput is 1 entry/cycle while out_ready=1.
- Next-state rules:
  - M empty, or M leaving: M <= S if S is valid, otherwise M <= input if there is an input transfer.
  - When S moves to M and an input transfer occurs in the same cycle, the input goes to S.
  - M valid, not leaving, input transfer: input goes to S, and in_ready drops on the next cycle.
  - Order is preserved at all times.
- Branch evaluation is done on the input side and stored with the entry. With N,Z,C,V = flags of A-B:
  - 000 BEQ: Z
  - 001 BNE: ~Z
  - 100 BLT: N^V
  - 101 BGE: ~(N^V)
  - 110 BLTU: ~C
  - 111 BGEU: C
  - 010 and 011: taken=0, illegal=1.
  - For any entry with in_branch=0: taken=0, illegal=0.
- out_target is computed for every entry; it is meaningful only when taken=1.
- last_flags is updated with in_flags on every input transfer, including branches. It is not cleared by flush.
- flush=1: M.valid and S.valid <= 0 at the next edge. Any input transfer in the same cycle is dropped.
  - in_ready is 1 in the following cycle.
  - last_flags still captures that cycle's flags if an input transfer occurred.
- Simultaneous input and output transfer with S empty: M is replaced by the input and out_valid stays 1.
- Reset asserted mid-transfer: entries are lost immediately. There is no partial state.

Decomposition:
- Shared package alu_pkg:
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - branch funct3 constants F3_BEQ..F3_BGEU
  - a packed struct for the stage entry {result, rd, regwrite, taken, target, illegal}
- One natural sub-module: branch_cond, purely combinational (flags, funct3, branch -> taken, illegal). It is reused by any later compare unit.

Test Plan:
- BEQ taken, BNE not taken: in_flags=4'b0110 (Z=1,C=1), funct3=000, pc=0x100, imm=0x20 -> next cycle out_valid=1, out_taken=1, out_target=0x120, out_regwrite=0. Same flags with funct3=001 -> out_taken=0.
- Signed vs unsigned: A=0xFFFFFFFF, B=1 gives flags N=1,Z=0,C=1,V=0. BLT -> taken=1; BLTU -> taken=0; BGEU -> taken=1. Target wrap: pc=0xFFFFFFF0, imm=0x20 -> target=0x00000010.
- Backpressure: stream 3 entries (results 0xA,0xB,0xC) with out_ready=0:
  - in_ready=1, 1, then 0 after the 2nd entry is accepted; the 3rd entry is held upstream.
  - out_result stays 0xA.
  - Release out_ready -> outputs 0xA, 0xB, 0xC in order on consecutive cycles.
- Full throughput: 8 back-to-back entries with out_ready=1 -> each appears exactly 1 cycle later, and in_ready stays 1.
- Flush while full, plus illegal funct3:
  - Fill M and S, assert flush together with in_valid -> next cycle out_valid=0 and in_ready=1, and the flushed-cycle entry never appears at the output.
  - A later entry with funct3=010 and in_branch=1 -> out_illegal=1, out_taken=0.
- Async reset mid-stream: drop reset_n between clock edges while out_valid=1 -> out_valid=0, in_ready=1 and last_flags=0 immediately (before the next clock edge). After release, the first new entry appears 1 cycle after it is accepted.
